// File: rtl/register_file_v2.sv
// register_file_v2: DEPTH x WIDTH register file with two read ports, one write port and a register dump engine.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file_v2 #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [WIDTH-1:0] regs_q [DEPTH];
    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             wr_ok;
    logic [WIDTH-1:0] stored_a, stored_b;

    // A write aimed at a hardwired r0 is dropped here so r0 never holds anything but zero.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Register array: cleared by reset, at most one write per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign stored_a  = ((ZERO_REG != 0) && (rd_addr_a == '0)) ? '0 : regs_q[rd_addr_a];
    assign stored_b  = ((ZERO_REG != 0) && (rd_addr_b == '0)) ? '0 : regs_q[rd_addr_b];
    assign dump_data = ((ZERO_REG != 0) && (idx_q == '0))     ? '0 : regs_q[idx_q];

`ifdef REGFILE_BYPASS_EN
    assign rd_data_a = (wr_ok && (rd_addr_a == wr_addr)) ? wr_data : stored_a;
    assign rd_data_b = (wr_ok && (rd_addr_b == wr_addr)) ? wr_data : stored_b;
`else
    assign rd_data_a = stored_a;
    assign rd_data_b = stored_b;
`endif

    assign dump_idx  = idx_q;
    assign dump_busy = (state_q != IDLE);

    // Dump engine state and beat index; reset aborts any dump in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump sequencing: one beat per accepted handshake, then a single done cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (idx_q == AW'(DEPTH - 1)) state_d = DONE;
                    else idx_d = idx_q + AW'(1);
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_d   = IDLE;
                idx_d     = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_register_file_v2.sv
// tb_register_file_v2: randomized check of register_file_v2 against a behavioural model.
module tb_register_file_v2;
    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [3:0]   ra = '0, rb = '0;
    logic [W-1:0] rd_data_a, rd_data_b;
    logic         dump_start = 1'b0, dump_ready = 1'b0;
    logic         dump_valid, dump_busy, dump_done;
    logic [3:0]   dump_idx;
    logic [W-1:0] dump_data;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] mregs [D];
    int m_beat = -1;
    int done_seen = 0;
    bit aborted = 0;

    register_file_v2 #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rd_data_a),
        .rd_addr_b(rb), .rd_data_b(rd_data_b),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [3:0] a);
        logic [W-1:0] v;
        v = (a == 0) ? '0 : mregs[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == wr_addr && a != 0) v = wr_data;
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) mregs[i] = '0;
        m_beat = -1;
    endtask

    // Compare outputs after inputs settle, advance one clock, update the model.
    task automatic cycle();
        bit sending;
        #1;
        sending = (m_beat >= 0 && m_beat < D);
        chk("rd_a", rd_data_a, exp_rd(ra));
        chk("rd_b", rd_data_b, exp_rd(rb));
        chk("valid", dump_valid, sending);
        chk("busy", dump_busy, m_beat >= 0);
        chk("done", dump_done, m_beat == D);
        if (sending) begin
            chk("idx", dump_idx, m_beat);
            chk("data", dump_data, (m_beat == 0) ? '0 : mregs[m_beat]);
        end else if (m_beat < 0) chk("idx_idle", dump_idx, 0);
        if (dump_done) done_seen++;
        @(posedge clk);
        if (m_beat < 0) begin
            if (dump_start) m_beat = 0;
        end else if (m_beat == D) m_beat = -1;
        else if (dump_ready) m_beat++;
        if (wr_en && wr_addr != 0) mregs[wr_addr] = wr_data;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_clear();
        chk("rst_rd_a", rd_data_a, 0);
        chk("rst_rd_b", rd_data_b, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_busy", dump_busy, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_idx", dump_idx, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();
        // write r0 and r5, then reset mid-cycle
        wr(4'd0, 16'hBEEF);
        wr(4'd5, 16'h1234);
        ra = 4'd5; rb = 4'd0;
        cycle();
        do_reset();
        wr(4'd0, 16'hBEEF);
        ra = 4'd0; rb = 4'd5;
        cycle();
        // dual read
        wr(4'd3, 16'hAAAA);
        wr(4'd7, 16'h5555);
        ra = 4'd3; rb = 4'd7;
        cycle();
        chk("dual_a", rd_data_a, 16'hAAAA);
        chk("dual_b", rd_data_b, 16'h5555);
        ra = 4'd7;
        cycle();
        // same-cycle write and read of r4
        ra = 4'd4; rb = 4'd4;
        wr(4'd4, 16'hC0DE);
        cycle();
        chk("bypass_next", rd_data_a, 16'hC0DE);
        // full dump with ready held high
        for (int n = 0; n < D; n++) wr(4'(n), 16'(n * 16'h0101));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        done_seen = 0;
        for (int c = 0; c < D + 3; c++) cycle();
        chk("dump_done_count", done_seen, 1);
        // randomized traffic with backpressure and one mid-dump reset
        for (int c = 0; c < 600; c++) begin
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_addr    = 4'($urandom);
            wr_data    = 16'($urandom);
            ra         = 4'($urandom);
            rb         = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom);
            dump_ready = $urandom_range(0, 1) != 0;
            dump_start = ($urandom_range(0, 5) == 0);
            if (!aborted && m_beat == 6) begin
                aborted = 1;
                do_reset();
                done_seen = 0;
            end else cycle();
        end
        chk("abort_seen", aborted, 1);
        wr_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        for (int c = 0; c < D + 3; c++) cycle();
        chk("drain_idle", dump_busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/register_file_v2.md
# register_file_v2

Parametrised successor to the Hmmm CPU register file. Provides DEPTH registers of WIDTH bits, with two independent read ports and one write port in place of the shared tri-state bus, and an optional hardwired-zero r0. A built-in dump engine streams every register out over a valid/ready handshake for debug and scan-out from the Caravel harness. It sits between the control unit and the ALU/memory datapath.

## Interface
- WIDTH, 16, register width in bits (≥1)
- DEPTH, 16, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = r0 is an ordinary register

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserts immediately, deassert synchronised externally)
- wr_en  in  1  write strobe
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- rd_addr_a  in  AW  read port A index
- rd_data_a  out  WIDTH  read port A data (combinational)
- rd_addr_b  in  AW  read port B index
- rd_data_b  out  WIDTH  read port B data (combinational)
- dump_start  in  1  request a full register dump (sampled in IDLE only)
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts dump beat
- dump_idx  out  AW  index of register on dump_data
- dump_data  out  WIDTH  register contents for current beat
- dump_busy  out  1  dump engine not IDLE
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Reset (rst=0): all registers 0, FSM to IDLE, dump_idx 0, dump_valid/dump_busy/dump_done 0. Read outputs therefore 0.
- Write: on clk rising edge with wr_en=1, registers[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, write discarded.
- Read: rd_data_x = registers[rd_addr_x]; forced 0 when ZERO_REG=1 and rd_addr_x=0. Both ports may address the same register.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start=1 -> SEND, dump_idx <= 0. Otherwise stay.
  - SEND: dump_valid=1, dump_data = stored value of registers[dump_idx] (r0 reads 0 when ZERO_REG=1; never bypassed). On dump_valid&&dump_ready: if dump_idx = DEPTH-1 -> DONE, else dump_idx+1. Without ready, dump_idx and dump_valid hold.
  - DONE: dump_done=1 for exactly one cycle, then IDLE, dump_idx <= 0.
  - dump_busy = (state != IDLE). dump_start while busy is ignored.
- Writes continue during a dump; a beat shows the register value at the cycle of acceptance (a write to dump_idx lands on the following beat cycle if ready is low).
- Reset mid-dump: immediately aborts to IDLE; no dump_done pulse.

## Timing
- Read latency 0 cycles (combinational from address and stored state).
- Write-to-read latency 1 cycle without bypass (see Configuration).
- Dump: first beat valid 1 cycle after dump_start accepted; with dump_ready held high, DEPTH beats in DEPTH consecutive cycles, dump_done in cycle DEPTH+1 after start, dump_busy falls the cycle after.
- Total dump with ready tied high: DEPTH+2 cycles from start sample to IDLE.

## Configuration
- REGFILE_BYPASS_EN defined: if wr_en=1 and rd_addr_x = wr_addr (and not the zero register), rd_data_x returns wr_data in the same cycle (write-through forwarding). Dump path is never bypassed.
- REGFILE_BYPASS_EN undefined: reads return only stored values; a same-cycle write is visible the next cycle.

## Test plan
- Reset/zero: write 16'hBEEF to r0 and 16'h1234 to r5, assert rst=0 mid-cycle -> all reads 0 immediately; after release read r0=0 even after another r0 write (ZERO_REG=1).
- Dual read: write r3=16'hAAAA, r7=16'h5555; rd_addr_a=3, rd_addr_b=7 -> A=16'hAAAA, B=16'h5555; both ports at 7 -> both 16'h5555.
- Bypass: wr_en=1, wr_addr=4, wr_data=16'hC0DE, rd_addr_a=4 same cycle -> A=16'hC0DE with REGFILE_BYPASS_EN, old value (0) without; next cycle 16'hC0DE in both builds.
- Dump streaming: load rN=N*16'h0101, pulse dump_start, dump_ready=1 -> 16 beats idx 0..15, data 0,16'h0101..16'h0F0F, dump_done one cycle after beat 15, dump_busy low one cycle later.
- Backpressure + abort: toggle dump_ready pseudo-randomly -> no beat skipped or duplicated, dump_idx stable while ready=0, dump_start during dump ignored; assert rst at beat 6 -> dump_valid=0 immediately, no dump_done.
